dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between the RISC-V core's load/store path (port 0) and a second bus master such as a debug/loader or DMA engine (port 1). It sits between the requesters and `dmem`, presents one address/data/write-enable set to the memory, and returns registered read data to whichever port issued a read. Arbitration is round-robin, with an optional bounded lock for atomic multi-access sequences.

## Interface
- `DATA_W`, 32: data width
- `ADDR_W`, 32: address width
- `MAX_LOCK`, 8: maximum consecutive cycles one port may hold a lock, range 1..255

- `clk`  in  1: clock, all logic on rising edge
- `reset`  in  1: synchronous, active-low reset
- `m0_req` / `m1_req`  in  1: access request
- `m0_we` / `m1_we`  in  1: 1 = write, 0 = read
- `m0_lock` / `m1_lock`  in  1: hold ownership after this access
- `m0_addr` / `m1_addr`  in  ADDR_W: byte address
- `m0_wdata` / `m1_wdata`  in  DATA_W: write data
- `m0_gnt` / `m1_gnt`  out  1: access accepted this cycle (combinational)
- `m0_rvalid` / `m1_rvalid`  out  1: read data valid, one cycle after a granted read
- `m0_rdata` / `m1_rdata`  out  DATA_W: registered read data
- `mem_we`  out  1: to `dmem` write enable
- `mem_addr`  out  ADDR_W: to `dmem` address
- `mem_wdata`  out  DATA_W: to `dmem` write data
- `mem_rdata`  in  DATA_W: from `dmem`, combinational read
- `owner`  out  2: status; 00 = idle, 01 = m0 locked, 10 = m1 locked

## Operation
- **State machine states:** IDLE, OWN0, OWN1.
- **Round-robin pointer `rr`:**
  - 0 favors m0; 1 favors m1.
  - After any IDLE-state grant, `rr` points at the other port.
- **IDLE:**
  - One requester: that requester is granted.
  - Both requesters: the port selected by `rr` is granted.
  - If the granted port has `lock`=1, next state is OWNx and the lock counter loads 1.
- **OWNx:**
  - Only port x can be granted.
  - The other port's `gnt` is 0 even if it requests.
  - The lock counter increments every cycle in OWNx, whether or not x requests.
- **Leaving OWNx:** the FSM returns to IDLE when either of these occurs:
  - a granted access has `lock`=0 (that access is the last one), or
  - the counter reaches `MAX_LOCK`.
- **Forced release:** on a counter-limit exit, `rr` is set to the other port. A waiting requester therefore wins the next cycle.
- **Memory drive:**
  - When a port is granted, `mem_addr`/`mem_wdata` equal that port's values and `mem_we` equals `gnt & we`.
  - With no grant, `mem_we`=0 and `mem_addr`/`mem_wdata` are 0.
- **Reads:**
  - On a granted read, `mem_rdata` is captured into that port's `rdata` register.
  - `rvalid` pulses for exactly one cycle.
  - `rdata` holds until that port's next granted read.
- **Writes:** produce no `rvalid`.

## Timing
- **Grant latency:** `gnt` is a Mealy output, asserted in the same cycle as `req`. A write commits in `dmem` at the clock edge that ends the grant cycle.
- **Read latency:** 1 cycle from the grant to `rvalid`/`rdata`.
- **Back-to-back access:** a port may be granted every cycle.
- **Throughput:** one access per cycle total.
- **Reset values** (on `reset`=0 at a clock edge):
  - state IDLE, `rr`=0, lock counter 0, `owner`=00
  - both `rvalid`=0, both `rdata`=0
  - `mem_*` outputs 0; all `gnt` outputs 0 while `reset` is low.
- **Reset mid-lock:** ownership is dropped immediately and no `rvalid` follows a read granted in the reset cycle.
- **Simultaneous events:**
  - Lock release plus a competing request in the same cycle: the competitor is considered starting the next cycle.
  - `MAX_LOCK`=1: a lock never spans more than one extra idle cycle.
- **Lock counter:** `ceil(log2(MAX_LOCK+1))` bits, saturates at `MAX_LOCK`, never wraps.

## Structure
- **Package `dmem_arb_pkg`:**
  - state enum `arb_state_t` (IDLE, OWN0, OWN1)
  - `owner` encodings `OWN_NONE`/`OWN_M0`/`OWN_M1`
  - port index constants `PORT_CORE`=0, `PORT_EXT`=1
- **Sub-module `arb_lock_timer`:** the lock counter, with inputs load/enable/clear and a limit-reached output. Everything else stays flat in `dmem_arbiter`.
- **Placement:** instantiated in the top level between `riscv`/external master and `dmem`. The core treats `!m0_gnt` as a memory stall.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with both requests high -> all `gnt`, `rvalid`, `mem_we`, `owner` = 0.
- **Single write then read:**
  - m0 writes 0xDEADBEEF to 0x40 -> `m0_gnt`=1 same cycle, `mem_we`=1.
  - m0 then reads 0x40 -> next cycle `m0_rvalid`=1, `m0_rdata`=0xDEADBEEF.
- **Contention:** both ports read every cycle for 4 cycles from reset -> grants alternate m0, m1, m0, m1. Each `rvalid` lands on the correct port one cycle later.
- **Lock with release:** m1 requests with `lock`=1 for 3 cycles, then `lock`=0 on the 4th, while m0 requests throughout:
  - `owner`=10 during the lock, `m0_gnt`=0 for those 4 cycles
  - m0 is granted in cycle 5.
- **Lock limit:** `MAX_LOCK`=8, m0 holds `lock`=1 indefinitely while m1 requests -> after 8 OWN0 cycles the FSM returns to IDLE and `m1_gnt`=1 on the next cycle.
- **Reset mid-lock:** assert `reset`=0 during OWN1 with a read granted -> state IDLE, no `m1_rvalid` pulse, m0 is granted first after reset release.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and encodings for the two-port data-memory arbiter.
// Imported by the arbiter top level and its lock timer.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_EXT  = 1'b1;

    function automatic logic [1:0] owner_of(input arb_state_t s);
        case (s)
            OWN0:    return OWN_M0;
            OWN1:    return OWN_M1;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/arb_lock_timer.sv
// Saturating lock-hold counter: load starts a hold at 1, enable counts up to
// MAX_LOCK and sticks there, clear returns to 0. limit flags the final hold cycle.
module arb_lock_timer #(
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    input  logic clear,
    output logic limit
);

    localparam int unsigned CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LIMIT_VAL = CW'(MAX_LOCK);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(1);
        end else if (enable && (cnt != LIMIT_VAL)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign limit = (cnt == LIMIT_VAL);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported dmem between the core (m0)
// and an external master (m1), with a bounded lock for atomic sequences.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    arb_state_t state, next_state;
    logic       rr;
    logic       lock_limit;
    logic       lt_load, lt_clear, lt_enable;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A lock ends either on an unlocked access by the owner or on the hold limit.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (m0_gnt && m0_lock) begin
                    next_state = OWN0;
                end else if (m1_gnt && m1_lock) begin
                    next_state = OWN1;
                end
            end
            OWN0: begin
                if ((m0_gnt && !m0_lock) || lock_limit) begin
                    next_state = IDLE;
                end
            end
            OWN1: begin
                if ((m1_gnt && !m1_lock) || lock_limit) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (m0_req && (!m1_req || (rr == PORT_CORE))) begin
                        m0_gnt = 1'b1;
                    end else if (m1_req) begin
                        m1_gnt = 1'b1;
                    end
                end
                OWN0:    m0_gnt = m0_req;
                OWN1:    m1_gnt = m1_req;
                default: ;
            endcase
        end
        if (m0_gnt) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_gnt) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    assign owner = owner_of(state);

    assign lt_enable = (state != IDLE);
    assign lt_load   = (state == IDLE) && (next_state != IDLE);
    assign lt_clear  = (state != IDLE) && (next_state == IDLE);

    arb_lock_timer #(
        .MAX_LOCK (MAX_LOCK)
    ) u_lock_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (lt_load),
        .enable (lt_enable),
        .clear  (lt_clear),
        .limit  (lock_limit)
    );

    // A forced release hands priority to the port that was kept waiting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr <= PORT_CORE;
        end else if (state == IDLE) begin
            if (m0_gnt) begin
                rr <= PORT_EXT;
            end else if (m1_gnt) begin
                rr <= PORT_CORE;
            end
        end else if (lock_limit) begin
            rr <= (state == OWN0) ? PORT_EXT : PORT_CORE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= m0_gnt && !m0_we;
            m1_rvalid <= m1_gnt && !m1_we;
            if (m0_gnt && !m0_we) begin
                m0_rdata <= mem_rdata;
            end
            if (m1_gnt && !m1_we) begin
                m1_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: the driver queues expected grant/memory
// records and read data; a negedge monitor pops and compares them.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req = 0, m0_we = 0, m0_lock = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0;
    logic        m1_req = 0, m1_we = 0, m1_lock = 0;
    logic [31:0] m1_addr = 0, m1_wdata = 0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  owner;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_LOCK(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    // Memory model: unwritten words read back as 0xC0DE0000 | word index.
    logic [31:0] mem_data [0:255];
    logic        mem_vld  [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem_vld[i] = 1'b0;
    end
    always_comb begin
        mem_rdata = mem_vld[mem_addr[9:2]] ? mem_data[mem_addr[9:2]]
                                           : (32'hC0DE_0000 | {24'h0, mem_addr[9:2]});
    end
    always @(posedge clk) begin
        if (mem_we) begin
            mem_data[mem_addr[9:2]] <= mem_wdata;
            mem_vld[mem_addr[9:2]]  <= 1'b1;
        end
    end

    typedef struct {
        logic        g0, g1, we;
        logic [31:0] addr, wdata;
        logic [1:0]  own;
    } gexp_t;

    gexp_t       gq[$];
    logic [31:0] rq0[$];
    logic [31:0] rq1[$];
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        gexp_t e;
        if (gq.size() > 0) begin
            e = gq.pop_front();
            chk("m0_gnt", {31'h0, m0_gnt}, {31'h0, e.g0});
            chk("m1_gnt", {31'h0, m1_gnt}, {31'h0, e.g1});
            chk("mem_we", {31'h0, mem_we}, {31'h0, e.we});
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_wdata", mem_wdata, e.wdata);
            chk("owner", {30'h0, owner}, {30'h0, e.own});
        end
        if (m0_rvalid) begin
            if (rq0.size() == 0) begin
                n_checks++;
                $display("FAIL m0_rvalid_unexpected: got 1 expected 0 at %0t", $time);
            end else chk("m0_rdata", m0_rdata, rq0.pop_front());
        end
        if (m1_rvalid) begin
            if (rq1.size() == 0) begin
                n_checks++;
                $display("FAIL m1_rvalid_unexpected: got 1 expected 0 at %0t", $time);
            end else chk("m1_rdata", m1_rdata, rq1.pop_front());
        end
    end

    // One cycle of stimulus with hand-computed grant, owner and read data.
    task automatic step(input logic rst_n,
                        input logic r0, input logic w0, input logic l0,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic l1,
                        input logic [31:0] a1, input logic [31:0] d1,
                        input logic eg0, input logic eg1, input logic [1:0] eown,
                        input logic [31:0] erd);
        gexp_t e;
        reset = rst_n;
        m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
        e.g0 = eg0; e.g1 = eg1; e.own = eown;
        e.we = 1'b0; e.addr = 32'h0; e.wdata = 32'h0;
        if (eg0) begin
            e.we = w0; e.addr = a0; e.wdata = d0;
            if (!w0) rq0.push_back(erd);
        end else if (eg1) begin
            e.we = w1; e.addr = a1; e.wdata = d1;
            if (!w1) rq1.push_back(erd);
        end
        gq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1, 0,0,0,0,0, 0,0,0,0,0, 0,0,2'b00,0);
    endtask

    task automatic drained(input string name);
        chk({name, "_rq0_left"}, rq0.size(), 0);
        chk({name, "_rq1_left"}, rq1.size(), 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset held with both requesting
        step(0, 1,0,0,32'h10,0, 1,0,0,32'h14,0, 0,0,2'b00,0);
        step(0, 1,0,0,32'h10,0, 1,0,0,32'h14,0, 0,0,2'b00,0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        chk("rst_rvalid", {30'h0, m0_rvalid, m1_rvalid}, 32'h0);

        // Single write then read
        step(1, 1,1,0,32'h40,32'hDEADBEEF, 0,0,0,0,0, 1,0,2'b00,0);
        step(1, 1,0,0,32'h40,0, 0,0,0,0,0, 1,0,2'b00,32'hDEADBEEF);
        idle();
        drained("wr_rd");

        // Contention from reset: m0, m1, m0, m1
        step(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,2'b00,0);
        step(1, 1,0,0,32'h10,0, 1,0,0,32'h20,0, 1,0,2'b00,32'hC0DE0004);
        step(1, 1,0,0,32'h14,0, 1,0,0,32'h24,0, 0,1,2'b00,32'hC0DE0009);
        step(1, 1,0,0,32'h18,0, 1,0,0,32'h28,0, 1,0,2'b00,32'hC0DE0006);
        step(1, 1,0,0,32'h1C,0, 1,0,0,32'h2C,0, 0,1,2'b00,32'hC0DE000B);
        idle();
        drained("contention");

        // Lock with release: m0 alone first so rr favors m1
        step(1, 1,0,0,32'h00,0, 0,0,0,0,0, 1,0,2'b00,32'hC0DE0000);
        step(1, 1,0,0,32'h04,0, 1,0,1,32'h30,0, 0,1,2'b00,32'hC0DE000C);
        step(1, 1,0,0,32'h04,0, 1,0,1,32'h34,0, 0,1,2'b10,32'hC0DE000D);
        step(1, 1,0,0,32'h04,0, 1,0,1,32'h38,0, 0,1,2'b10,32'hC0DE000E);
        step(1, 1,0,0,32'h04,0, 1,0,0,32'h3C,0, 0,1,2'b10,32'hC0DE000F);
        step(1, 1,0,0,32'h04,0, 1,0,0,32'h30,0, 1,0,2'b00,32'hC0DE0001);
        idle();
        drained("lock_release");

        // Lock limit: m1 write alone so rr favors m0, then m0 locks forever
        step(1, 0,0,0,0,0, 1,1,0,32'h80,32'h12345678, 0,1,2'b00,0);
        step(1, 1,0,1,32'h08,0, 1,0,0,32'h0C,0, 1,0,2'b00,32'hC0DE0002);
        for (int k = 0; k < 8; k++)
            step(1, 1,0,1,32'h08,0, 1,0,0,32'h0C,0, 1,0,2'b01,32'hC0DE0002);
        step(1, 1,0,1,32'h08,0, 1,0,0,32'h0C,0, 0,1,2'b00,32'hC0DE0003);
        idle();
        drained("lock_limit");

        // Reset during OWN1 with a read presented
        step(1, 0,0,0,0,0, 1,0,1,32'h14,0, 0,1,2'b00,32'hC0DE0005);
        step(1, 1,0,0,32'h1C,0, 1,0,1,32'h18,0, 0,1,2'b10,32'hC0DE0006);
        step(0, 1,0,0,32'h1C,0, 1,0,1,32'h1C,0, 0,0,2'b10,0);
        step(1, 1,0,0,32'h1C,0, 1,0,1,32'h20,0, 1,0,2'b00,32'hC0DE0007);
        idle();
        idle();
        drained("rst_lock");
        chk("hold_m0_rdata", m0_rdata, 32'hC0DE0007);
        chk("rst_cleared_m1_rdata", m1_rdata, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
